// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of a single uart_tx among N_REQ byte
// streams. Each accepted byte produces one uart_start pulse. The next byte is
// accepted only after uart_done. Packet lock keeps the grant on one requester
// until its last byte. A watchdog abandons a frame or a lock that stalls.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int CLK_FREQ       = 50000000,
    parameter int BAUD_RATE      = 19200,
    parameter int TIMEOUT_CYCLES = 12 * (CLK_FREQ / BAUD_RATE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     uart_start,
    output logic [7:0]               uart_data,
    input  logic                     uart_done,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     timeout_err
);

    localparam int          ID_W = $clog2(N_REQ);
    localparam int          WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned NU   = N_REQ;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic              last_q, last_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              start_q, start_d;

    logic              found;
    logic [ID_W-1:0]   winner;
    logic [31:0]       scan_idx;
    logic [31:0]       next_ptr_full;
    logic [ID_W-1:0]   next_ptr;
    logic [N_REQ-1:0]  ready_c;
    logic              timeout_c;

    // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int unsigned j = 0; j < NU; j++) begin
            scan_idx = (32'(rr_ptr_q) + j) % NU;
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx[ID_W-1:0];
            end
        end
    end

    // Pointer position just past the current grant, modulo N_REQ.
    always_comb begin
        next_ptr_full = (32'(grant_q) + 32'd1) % NU;
        next_ptr      = next_ptr_full[ID_W-1:0];
    end

    // Next-state, accept handshake and watchdog logic.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        grant_d   = grant_q;
        last_d    = last_q;
        rr_ptr_d  = rr_ptr_q;
        wdog_d    = wdog_q;
        ready_c   = '0;
        timeout_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    ready_c[winner] = 1'b1;
                    grant_d         = winner;
                    data_d          = req_data[8*int'(winner) +: 8];
                    last_d          = req_last[winner];
                    state_d         = ST_START;
                end
            end
            ST_START: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wdog_d = wdog_q + WD_W'(1);
                // A done in the terminal-count cycle takes precedence over the timeout.
                if (uart_done) begin
                    if (last_q) begin
                        rr_ptr_d = next_ptr;
                        state_d  = ST_IDLE;
                    end else begin
                        wdog_d  = '0;
                        state_d = ST_HOLD;
                    end
                end else if (wdog_q == WD_LAST) begin
                    timeout_c = 1'b1;
                    rr_ptr_d  = next_ptr;
                    state_d   = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (req_valid[grant_q]) begin
                    ready_c[grant_q] = 1'b1;
                    data_d           = req_data[8*int'(grant_q) +: 8];
                    last_d           = req_last[grant_q];
                    state_d          = ST_START;
                end else if (wdog_q == WD_LAST) begin
                    timeout_c = 1'b1;
                    rr_ptr_d  = next_ptr;
                    state_d   = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        start_d = (state_d == ST_START);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            grant_q  <= '0;
            last_q   <= 1'b0;
            rr_ptr_q <= '0;
            wdog_q   <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            rr_ptr_q <= rr_ptr_d;
            wdog_q   <= wdog_d;
            start_q  <= start_d;
        end
    end

    // Handshake and timeout are masked while rst is high so no byte is taken during reset.
    always_comb begin
        req_ready   = ready_c & {N_REQ{~rst}};
        timeout_err = timeout_c & ~rst;
        uart_start  = start_q;
        uart_data   = data_q;
        busy        = (state_q != ST_IDLE);
        grant_id    = grant_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. The bench plays the uart_tx role by
// pulsing uart_done after a chosen latency. It predicts grants from a
// transaction-level round-robin and lock model.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int TMO = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]  req_last = '0;
    logic [N-1:0]  req_ready;
    logic          uart_start;
    logic [7:0]    uart_data;
    logic          uart_done = 1'b0;
    logic          busy;
    logic [1:0]    grant_id;
    logic          timeout_err;

    uart_tx_arbiter #(
        .N_REQ         (N),
        .CLK_FREQ      (800),
        .BAUD_RATE     (100),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .uart_start (uart_start),
        .uart_data  (uart_data),
        .uart_done  (uart_done),
        .busy       (busy),
        .grant_id   (grant_id),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int model_ptr   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int idx, input logic [7:0] d, input logic last);
        req_data[8*idx +: 8] = d;
        req_last[idx]        = last;
        req_valid[idx]       = 1'b1;
    endtask

    // Wait (bounded) for an accept, check it, then check the START cycle.
    task automatic accept(input int idx, input logic [7:0] d, input bit keep);
        int n = 0;
        #1;
        while (req_ready == '0 && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk("req_ready_onehot", 32'(req_ready), 32'(1) << idx);
        tick();
        if (!keep) req_valid[idx] = 1'b0;
        chk("uart_start_pulse", 32'(uart_start), 1);
        chk("uart_data", 32'(uart_data), 32'(d));
        chk("grant_id", 32'(grant_id), idx);
        chk("busy_in_frame", 32'(busy), 1);
    endtask

    // Let the frame run for lat cycles, then pulse done.
    task automatic finish(input logic [7:0] d, input int lat, input bit last, input int idx);
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("start_single_cycle", 32'(uart_start), 0);
            chk("ready_low_in_wait", 32'(req_ready), 0);
            chk("no_timeout_in_wait", 32'(timeout_err), 0);
        end
        chk("data_held", 32'(uart_data), 32'(d));
        uart_done = 1'b1;
        tick();
        uart_done = 1'b0;
        chk("busy_after_done", 32'(busy), last ? 0 : 1);
        chk("timeout_after_done", 32'(timeout_err), 0);
        if (last) model_ptr = (idx + 1) % N;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        int order [6] = '{0, 1, 2, 3, 0, 1};
        int exp_idx;
        bit early;
        bit lock;
        int lock_id;
        logic [7:0] dv;
        logic lastb;
        logic [N-1:0] v;

        // Reset, with all requesters valid to show nothing is accepted.
        rst = 1'b1;
        req_valid = '1;
        repeat (3) tick();
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_uart_start", 32'(uart_start), 0);
        chk("rst_uart_data", 32'(uart_data), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        // Round-robin fairness with all four single-byte streams always valid.
        for (int i = 0; i < N; i++) set_req(i, 8'h10 + 8'(i), 1'b1);
        for (int k = 0; k < 6; k++) begin
            accept(order[k], 8'h10 + 8'(order[k]), 1'b1);
            finish(8'h10 + 8'(order[k]), 1 + int'($urandom_range(0, 19)), 1'b1, order[k]);
        end
        req_valid = '0;

        // Single byte from requester 0.
        set_req(0, 8'hA5, 1'b1);
        accept(0, 8'hA5, 1'b0);
        finish(8'hA5, 8, 1'b1, 0);
        chk("single_grant_id", 32'(grant_id), 0);

        // Packet lock: requester 1 sends three bytes while requester 2 waits.
        set_req(1, 8'h31, 1'b0);
        set_req(2, 8'h40, 1'b1);
        accept(1, 8'h31, 1'b0);
        finish(8'h31, 5, 1'b0, 1);
        set_req(1, 8'h32, 1'b0);
        accept(1, 8'h32, 1'b0);
        finish(8'h32, 7, 1'b0, 1);
        set_req(1, 8'h33, 1'b1);
        accept(1, 8'h33, 1'b0);
        finish(8'h33, 3, 1'b1, 1);
        accept(2, 8'h40, 1'b0);
        finish(8'h40, 4, 1'b1, 2);

        // Watchdog on a missing done: fires 100 cycles after START.
        set_req(3, 8'h77, 1'b1);
        accept(3, 8'h77, 1'b0);
        early = 1'b0;
        for (int i = 1; i < TMO; i++) begin
            tick();
            if (timeout_err) early = 1'b1;
        end
        chk("wait_timeout_early", 32'(early), 0);
        tick();
        chk("wait_timeout_pulse", 32'(timeout_err), 1);
        tick();
        chk("wait_timeout_single", 32'(timeout_err), 0);
        chk("wait_timeout_idle", 32'(busy), 0);
        model_ptr = (3 + 1) % N;
        set_req(1, 8'h5A, 1'b1);
        set_req(3, 8'h6B, 1'b1);
        accept(rr_pick(req_valid, model_ptr), 8'h5A, 1'b0);
        finish(8'h5A, 3, 1'b1, 1);
        req_valid = '0;

        // HOLD stall: lock on requester 0 with no follow-up byte.
        set_req(0, 8'h01, 1'b0);
        accept(0, 8'h01, 1'b0);
        finish(8'h01, 4, 1'b0, 0);
        set_req(1, 8'h55, 1'b1);
        #1;
        chk("hold_ignores_others", 32'(req_ready), 0);
        early = 1'b0;
        for (int i = 1; i < TMO - 1; i++) begin
            tick();
            if (timeout_err || req_ready != '0) early = 1'b1;
        end
        chk("hold_timeout_early", 32'(early), 0);
        tick();
        chk("hold_timeout_pulse", 32'(timeout_err), 1);
        tick();
        model_ptr = (0 + 1) % N;
        accept(1, 8'h55, 1'b0);
        finish(8'h55, 6, 1'b1, 1);

        // Reset 20 cycles into a frame; a late done is ignored.
        set_req(2, 8'h99, 1'b1);
        accept(2, 8'h99, 1'b0);
        repeat (20) tick();
        req_valid = '1;
        rst = 1'b1;
        tick();
        #1;
        chk("midrst_req_ready", 32'(req_ready), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_uart_start", 32'(uart_start), 0);
        chk("midrst_uart_data", 32'(uart_data), 0);
        chk("midrst_grant_id", 32'(grant_id), 0);
        chk("midrst_timeout", 32'(timeout_err), 0);
        req_valid = '0;
        rst = 1'b0;
        uart_done = 1'b1;
        tick();
        uart_done = 1'b0;
        chk("late_done_ignored", 32'(busy), 0);
        tick();
        chk("late_done_no_start", 32'(uart_start), 0);
        model_ptr = 0;
        set_req(1, 8'h21, 1'b1);
        set_req(3, 8'h23, 1'b1);
        accept(rr_pick(req_valid, model_ptr), 8'h21, 1'b0);
        finish(8'h21, 3, 1'b1, 1);
        req_valid = '0;

        // Randomized traffic against the round-robin / lock model.
        lock = 1'b0;
        lock_id = 0;
        for (int it = 0; it < 25; it++) begin
            v = N'($urandom_range(1, 15));
            if (lock) v[lock_id] = 1'b1;
            for (int i = 0; i < N; i++) begin
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]        = (it == 24) ? 1'b1 : 1'($urandom);
            end
            req_valid = v;
            exp_idx = lock ? lock_id : rr_pick(v, model_ptr);
            dv    = req_data[8*exp_idx +: 8];
            lastb = req_last[exp_idx];
            accept(exp_idx, dv, 1'b0);
            finish(dv, 1 + int'($urandom_range(0, 29)), lastb, exp_idx);
            req_valid = '0;
            lock    = !lastb;
            lock_id = exp_idx;
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
